csi_rx_header_ecc_core: RTL and testbench

//  MIPI CSI-2 packet-header ECC block for the receive path, after lane merge and before the packet parser.
//  - Computes the 6-bit Hamming ECC of a 24-bit header (DataID + WordCount).
//  - Checks the computed ECC against the received ECC byte.
//  - Corrects any single-bit error and flags uncorrectable (multi-bit) errors.
//  - One clock; one-cycle registered latency.

---
 rtl/csi_rx_header_ecc_core.sv | 112 +++++++++++
 tb/tb_csi_rx_header_ecc_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/csi_rx_header_ecc_core.sv
// rtl/csi_rx_header_ecc_core.sv - CSI-2 packet header ECC compute, check and single-bit correct
module csi_rx_header_ecc_core (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] DIN,
  input  logic        DIN_VALID,
  input  logic [7:0]  ECC_RX,
  output logic [7:0]  ECC,
  output logic [23:0] DOUT,
  output logic [5:0]  SYNDROME,
  output logic        OUT_VALID,
  output logic        ERR_CORR,
  output logic        ERR_UNCORR
);

  // Each row selects the header bits folded into one parity bit P0..P5.
  localparam logic [23:0] MASK_P0 = 24'hF12CB7;
  localparam logic [23:0] MASK_P1 = 24'hF2555B;
  localparam logic [23:0] MASK_P2 = 24'h749A6D;
  localparam logic [23:0] MASK_P3 = 24'hB8E38E;
  localparam logic [23:0] MASK_P4 = 24'hDF03F0;
  localparam logic [23:0] MASK_P5 = 24'hEFFC00;
  localparam logic [5:0][23:0] P_MASK = {MASK_P5, MASK_P4, MASK_P3,
                                         MASK_P2, MASK_P1, MASK_P0};

  logic [5:0]  parity;
  logic [5:0]  syndrome;
  logic [5:0]  col;
  logic [23:0] flip;
  logic        single_ecc_bit;
  logic        corr;
  logic        uncorr;

  logic [7:0]  ecc_q, ecc_d;
  logic [23:0] dout_q, dout_d;
  logic [5:0]  syn_q, syn_d;
  logic        vld_q, vld_d;
  logic        corr_q, corr_d;
  logic        uncorr_q, uncorr_d;

  // The top two received ECC bits carry no parity information.
  logic unused_ecc_rx_hi;
  assign unused_ecc_rx_hi = ^ECC_RX[7:6];

  // Parity, syndrome and decode: match the syndrome against every data-bit column.
  always_comb begin
    parity   = '0;
    col      = '0;
    flip     = '0;
    for (int k = 0; k < 6; k++) begin
      parity[k] = ^(DIN & P_MASK[k]);
    end
    syndrome = parity ^ ECC_RX[5:0];
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 6; k++) begin
        col[k] = P_MASK[k][n];
      end
      if (syndrome == col) begin
        flip[n] = 1'b1;
      end
    end
    // A lone syndrome bit points at the ECC byte itself; data columns all weigh >= 3.
    single_ecc_bit = (syndrome != 6'd0) && ((syndrome & (syndrome - 6'd1)) == 6'd0);
    corr           = (|flip) || single_ecc_bit;
    uncorr         = (syndrome != 6'd0) && !corr;
  end

  // Next-state for the output registers: capture on valid, otherwise hold.
  always_comb begin
    ecc_d    = ecc_q;
    dout_d   = dout_q;
    syn_d    = syn_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    vld_d    = 1'b0;
    if (DIN_VALID) begin
      ecc_d    = {2'b00, parity};
      dout_d   = uncorr ? DIN : (DIN ^ flip);
      syn_d    = syndrome;
      corr_d   = corr;
      uncorr_d = uncorr;
      vld_d    = 1'b1;
    end
  end

  // Output registers; reset wins over a header presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ecc_q    <= '0;
      dout_q   <= '0;
      syn_q    <= '0;
      vld_q    <= 1'b0;
      corr_q   <= 1'b0;
      uncorr_q <= 1'b0;
    end else begin
      ecc_q    <= ecc_d;
      dout_q   <= dout_d;
      syn_q    <= syn_d;
      vld_q    <= vld_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign ECC        = ecc_q;
  assign DOUT       = dout_q;
  assign SYNDROME   = syn_q;
  assign OUT_VALID  = vld_q;
  assign ERR_CORR   = corr_q;
  assign ERR_UNCORR = uncorr_q;

endmodule

// File: tb/tb_csi_rx_header_ecc_core.sv
// tb/tb_csi_rx_header_ecc_core.sv - self-checking bench for the CSI-2 header ECC core
module tb_csi_rx_header_ecc_core;

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] DIN;
  logic        DIN_VALID;
  logic [7:0]  ECC_RX;
  logic [7:0]  ECC;
  logic [23:0] DOUT;
  logic [5:0]  SYNDROME;
  logic        OUT_VALID;
  logic        ERR_CORR;
  logic        ERR_UNCORR;

  csi_rx_header_ecc_core dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .ECC_RX(ECC_RX),
    .ECC(ECC), .DOUT(DOUT), .SYNDROME(SYNDROME), .OUT_VALID(OUT_VALID),
    .ERR_CORR(ERR_CORR), .ERR_UNCORR(ERR_UNCORR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  int n_out  = 0;

  // Header bit indices per parity bit, straight from the parity equations; -1 pads.
  localparam int PLIST [6][14] = '{
    '{0, 1, 2, 4, 5, 7, 10, 11, 13, 16, 20, 21, 22, 23},
    '{0, 1, 3, 4, 6, 8, 10, 12, 14, 17, 20, 21, 22, 23},
    '{0, 2, 3, 5, 6, 9, 11, 12, 15, 18, 20, 21, 22, -1},
    '{1, 2, 3, 7, 8, 9, 13, 14, 15, 19, 20, 21, 23, -1},
    '{4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 22, 23, -1},
    '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 21, 22, 23, -1}
  };

  function automatic void check(string nm, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endfunction

  function automatic logic [5:0] m_ecc(logic [23:0] d);
    logic [5:0] p = '0;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 14; j++)
        if (PLIST[k][j] >= 0) p[k] = p[k] ^ d[PLIST[k][j]];
    return p;
  endfunction

  // Returns {ecc[7:0], dout[23:0], syndrome[5:0], corr, uncorr}.
  function automatic logic [39:0] m_decode(logic [23:0] d, logic [7:0] erx);
    logic [5:0]  p = m_ecc(d);
    logic [5:0]  s = p ^ erx[5:0];
    logic [23:0] o = d;
    logic        c = 1'b0;
    logic        u = 1'b0;
    if (s != 0) begin
      for (int n = 0; n < 24; n++) begin
        if (m_ecc(24'd1 << n) == s) begin
          o = d ^ (24'd1 << n);
          c = 1'b1;
        end
      end
      if (!c && $countones(s) == 1) c = 1'b1;
      if (!c) u = 1'b1;
    end
    return {2'b00, p, o, s, c, u};
  endfunction

  logic [39:0] e_res = '0;
  logic        e_vld = 1'b0;
  logic        started = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      e_res   <= '0;
      e_vld   <= 1'b0;
      started <= 1'b1;
    end else if (DIN_VALID) begin
      e_res <= m_decode(DIN, ECC_RX);
      e_vld <= 1'b1;
    end else begin
      e_vld <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      check("cycle", {23'd0, ECC, DOUT, SYNDROME, ERR_CORR, ERR_UNCORR, OUT_VALID},
                     {23'd0, e_res, e_vld});
      if (OUT_VALID) n_out++;
    end
  end

  task automatic drive(logic [23:0] d, logic [7:0] e, logic v, logic r);
    @(negedge CLK);
    DIN = d; ECC_RX = e; DIN_VALID = v; RST = r;
    if (v && !r) n_acc++;
    @(posedge CLK);
    #1;
  endtask

  logic [5:0] eccs [24];
  int dups;
  int light;

  initial begin
    RST = 1'b1; DIN = '0; DIN_VALID = 1'b0; ECC_RX = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_zero", {ECC, DOUT, SYNDROME, OUT_VALID, ERR_CORR, ERR_UNCORR}, 0);
    drive(24'h0, 8'h0, 1'b0, 1'b0);

    // T1
    drive(24'h01F037, 8'h3F, 1'b1, 1'b0);
    check("t1_ecc", ECC, 8'h3F);
    check("t1_syn", SYNDROME, 6'h00);
    check("t1_dout", DOUT, 24'h01F037);
    check("t1_flags_vld", {ERR_CORR, ERR_UNCORR, OUT_VALID}, 3'b001);
    drive(24'h0, 8'h0, 1'b0, 1'b0);
    check("hold_vld", OUT_VALID, 1'b0);
    check("hold_dout", DOUT, 24'h01F037);

    // T2
    drive(24'h000001, 8'h00, 1'b1, 1'b0);
    check("t2_ecc_d0", ECC, 8'h07);
    drive(24'h800000, 8'h00, 1'b1, 1'b0);
    check("t2_ecc_d23", ECC, 8'h3B);
    drive(24'h000000, 8'h00, 1'b1, 1'b0);
    check("t2_ecc_zero", ECC, 8'h00);
    for (int n = 0; n < 24; n++) begin
      drive(24'd1 << n, 8'h00, 1'b1, 1'b0);
      eccs[n] = ECC[5:0];
    end
    dups = 0; light = 0;
    for (int a = 0; a < 24; a++) begin
      if ($countones(eccs[a]) < 3) light++;
      for (int b = a + 1; b < 24; b++) if (eccs[a] == eccs[b]) dups++;
    end
    check("t2_distinct", dups, 0);
    check("t2_weight", light, 0);

    // T3
    drive(24'h01F036, 8'h3F, 1'b1, 1'b0);
    check("t3_syn", SYNDROME, 6'h07);
    check("t3_dout", DOUT, 24'h01F037);
    check("t3_flags", {ERR_CORR, ERR_UNCORR}, 2'b10);
    for (int n = 0; n < 24; n++) begin
      drive(24'h01F037 ^ (24'd1 << n), 8'h3F, 1'b1, 1'b0);
      check("t3_sweep", {ERR_CORR, ERR_UNCORR, DOUT}, {2'b10, 24'h01F037});
    end

    // T4
    drive(24'h01F037, 8'h3E, 1'b1, 1'b0);
    check("t4_syn", SYNDROME, 6'h01);
    check("t4_dout_flags", {ERR_CORR, ERR_UNCORR, DOUT}, {2'b10, 24'h01F037});
    for (int k = 0; k < 6; k++) begin
      drive(24'h01F037, 8'h3F ^ (8'd1 << k), 1'b1, 1'b0);
      check("t4_ecc_bit", {ERR_CORR, ERR_UNCORR, DOUT}, {2'b10, 24'h01F037});
    end
    drive(24'h01F037, 8'hFF, 1'b1, 1'b0);
    check("t4_hi_ignored", {SYNDROME, ERR_CORR, ERR_UNCORR}, 8'h00);

    // T5
    drive(24'h01F034, 8'h3F, 1'b1, 1'b0);
    check("t5_flags", {ERR_CORR, ERR_UNCORR}, 2'b01);
    check("t5_dout", DOUT, 24'h01F034);

    // T6
    drive(24'h123456, 8'h15, 1'b1, 1'b0);
    drive(24'h01F036, 8'h3F, 1'b1, 1'b0);
    drive(24'hABCDEF, 8'h2A, 1'b1, 1'b1);
    check("t6_reset_zero", {ECC, DOUT, SYNDROME, OUT_VALID, ERR_CORR, ERR_UNCORR}, 0);
    drive(24'h01F037, 8'h3F, 1'b1, 1'b0);
    check("t6_after_reset", {OUT_VALID, ECC, DOUT}, {1'b1, 8'h3F, 24'h01F037});
    for (int i = 0; i < 10000; i++) begin
      logic [23:0] d;
      logic [7:0]  e;
      int          m;
      d = 24'($urandom);
      m = $urandom_range(0, 3);
      case (m)
        0: e = {2'($urandom), m_ecc(d)};
        1: e = {2'($urandom), m_ecc(d) ^ 6'(1 << $urandom_range(0, 5))};
        2: begin e = {2'($urandom), m_ecc(d)}; d = d ^ (24'd1 << $urandom_range(0, 23)); end
        default: e = 8'($urandom);
      endcase
      drive(d, e, ($urandom_range(0, 7) != 0), ($urandom_range(0, 499) == 0));
    end
    drive(24'h0, 8'h0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    check("t6_valid_count", n_out, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
